latch_bank_write_ctrl: RTL and testbench



---
 rtl/latch_bank_write_ctrl.sv | 125 ++++++++++++
 tb/tb_latch_bank_write_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_write_ctrl.sv
// Write sequencer for a bank of active-low-set, high-transparent D latches.
// Every latch-facing output is taken straight from a flop so the latches never see glitches.
module latch_bank_write_ctrl #(
  parameter int WORDS       = 8,
  parameter int WIDTH       = 8,
  parameter int INIT_CYCLES = 2,
  parameter int AW          = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [AW-1:0]    REQ_ADDR,
  input  logic [WIDTH-1:0] REQ_DATA,
  input  logic             REQ_SET,
  output logic [WIDTH-1:0] LAT_D,
  output logic [WORDS-1:0] LAT_E,
  output logic             LAT_SETN,
  output logic             BUSY,
  output logic             WERR
);

  localparam int CW = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INIT_CYCLES);
  localparam logic [AW:0]   WORDS_W  = (AW + 1)'(WORDS);

  typedef enum logic [2:0] {
    S_PRESET,
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_CLOSE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [WORDS-1:0] e_q, e_d;
  logic             setn_q, setn_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             werr_q, werr_d;
  logic             fire;
  logic             addr_ok;

  // ready_q is high exactly while in IDLE, so it alone qualifies the handshake
  assign fire    = REQ_VALID && ready_q;
  assign addr_ok = ({1'b0, addr_q} < WORDS_W);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_PRESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PRESET: if (cnt_q == CNT_LAST) state_d = S_IDLE;
      S_IDLE: begin
        if (fire) state_d = REQ_SET ? S_PRESET : S_SETUP;
      end
      S_SETUP:  state_d = S_OPEN;
      S_OPEN:   state_d = S_CLOSE;
      S_CLOSE:  state_d = S_IDLE;
      default:  state_d = S_PRESET;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pin
  // changes on the same edge as the state it belongs to.
  always_comb begin
    cnt_d   = '0;
    addr_d  = addr_q;
    dat_d   = dat_q;
    e_d     = '0;
    setn_d  = (state_d != S_PRESET);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    werr_d  = (state_d == S_CLOSE) && !addr_ok;
    if (state_q == S_PRESET && state_d == S_PRESET) cnt_d = cnt_q + 1'b1;
    if (state_q == S_IDLE && fire && !REQ_SET) begin
      addr_d = REQ_ADDR;
      dat_d  = REQ_DATA;
    end
    if (state_d == S_OPEN && addr_ok) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (addr_q == AW'(i)) e_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      addr_q  <= '0;
      dat_q   <= '0;
      e_q     <= '0;
      setn_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      werr_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      e_q     <= e_d;
      setn_q  <= setn_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      werr_q  <= werr_d;
    end
  end

  assign REQ_READY = ready_q;
  assign LAT_D     = dat_q;
  assign LAT_E     = e_q;
  assign LAT_SETN  = setn_q;
  assign BUSY      = busy_q;
  assign WERR      = werr_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Randomized bench for latch_bank_write_ctrl against a transaction-level timeline model.
module tb_latch_bank_write_ctrl;

  localparam int WORDS = 6;
  localparam int WIDTH = 8;
  localparam int INIT  = 2;
  localparam int AW    = 3;
  localparam int MAXC  = 2048;

  logic             CLK = 1'b0;
  logic             RN;
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [AW-1:0]    REQ_ADDR;
  logic [WIDTH-1:0] REQ_DATA;
  logic             REQ_SET;
  logic [WIDTH-1:0] LAT_D;
  logic [WORDS-1:0] LAT_E;
  logic             LAT_SETN;
  logic             BUSY;
  logic             WERR;

  latch_bank_write_ctrl #(
    .WORDS(WORDS),
    .WIDTH(WIDTH),
    .INIT_CYCLES(INIT)
  ) dut (
    .CLK(CLK), .RN(RN), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_SET(REQ_SET),
    .LAT_D(LAT_D), .LAT_E(LAT_E), .LAT_SETN(LAT_SETN), .BUSY(BUSY), .WERR(WERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected pin values after each edge, indexed by edge number
  logic             exp_ready [MAXC];
  logic             exp_busy  [MAXC];
  logic             exp_setn  [MAXC];
  logic             exp_werr  [MAXC];
  logic [WORDS-1:0] exp_e     [MAXC];
  logic [WIDTH-1:0] model_d;
  logic             fired;
  int               fire_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_restart(input int c);
    for (int n = c; n < MAXC; n++) begin
      exp_ready[n] = 1'b1; exp_busy[n] = 1'b0; exp_setn[n] = 1'b1;
      exp_werr[n]  = 1'b0; exp_e[n]    = '0;
    end
    model_d = '0;
    for (int j = 0; j <= INIT; j++) begin
      exp_setn[c+j] = 1'b0; exp_ready[c+j] = 1'b0; exp_busy[c+j] = 1'b1;
    end
  endfunction

  function automatic void model_edge(input int n);
    fired = 1'b0;
    if (exp_ready[n-1] && REQ_VALID) begin
      fired    = 1'b1;
      fire_cyc = n;
      if (REQ_SET) begin
        for (int j = 0; j <= INIT; j++) begin
          exp_setn[n+j] = 1'b0; exp_ready[n+j] = 1'b0; exp_busy[n+j] = 1'b1;
        end
      end else begin
        model_d = REQ_DATA;
        for (int j = 0; j < 3; j++) begin
          exp_ready[n+j] = 1'b0; exp_busy[n+j] = 1'b1;
        end
        exp_e[n+1]    = (int'(REQ_ADDR) < WORDS) ? (WORDS'(1) << REQ_ADDR) : '0;
        exp_werr[n+2] = (int'(REQ_ADDR) >= WORDS);
      end
    end
  endfunction

  task automatic check_outputs();
    chk("ready", 64'(REQ_READY), 64'(exp_ready[cyc]));
    chk("busy",  64'(BUSY),      64'(exp_busy[cyc]));
    chk("setn",  64'(LAT_SETN),  64'(exp_setn[cyc]));
    chk("lat_e", 64'(LAT_E),     64'(exp_e[cyc]));
    chk("lat_d", 64'(LAT_D),     64'(model_d));
    chk("werr",  64'(WERR),      64'(exp_werr[cyc]));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_e"},     64'(LAT_E),     64'(0));
    chk({tag, "_setn"},  64'(LAT_SETN),  64'(0));
    chk({tag, "_d"},     64'(LAT_D),     64'(0));
    chk({tag, "_ready"}, 64'(REQ_READY), 64'(0));
    chk({tag, "_busy"},  64'(BUSY),      64'(1));
    chk({tag, "_werr"},  64'(WERR),      64'(0));
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    model_edge(cyc);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    RN = 1'b0;
    #1;
    check_reset_vals("rst_async");
    repeat (2) begin
      @(posedge CLK);
      #1;
      check_reset_vals("rst_hold");
    end
    @(negedge CLK);
    RN = 1'b1;
    model_restart(cyc);
  endtask

  task automatic do_req(input logic set, input logic [AW-1:0] a, input logic [WIDTH-1:0] dat,
                        input logic keep);
    int k;
    REQ_VALID = 1'b1; REQ_SET = set; REQ_ADDR = a; REQ_DATA = dat;
    fired = 1'b0;
    k = 0;
    while (!fired && k < 20) begin
      step();
      k++;
    end
    if (!fired) chk("hs_timeout", 64'(0), 64'(1));
    if (!keep) REQ_VALID = 1'b0;
  endtask

  initial begin
    int prev;
    RN = 1'b1; REQ_VALID = 1'b0; REQ_SET = 1'b0; REQ_ADDR = '0; REQ_DATA = '0;
    #2;
    do_reset();
    repeat (5) step();

    do_req(1'b0, 3'd5, 8'hA5, 1'b0);
    prev = fire_cyc;
    repeat (5) step();

    // back-to-back with REQ_VALID held continuously
    do_req(1'b0, 3'd0, 8'h11, 1'b1);
    prev = fire_cyc;
    do_req(1'b0, 3'd1, 8'h22, 1'b1);
    chk("b2b_gap1", 64'(fire_cyc - prev), 64'(4));
    prev = fire_cyc;
    do_req(1'b0, 3'd2, 8'h33, 1'b0);
    chk("b2b_gap2", 64'(fire_cyc - prev), 64'(4));
    repeat (5) step();

    do_req(1'b0, 3'd7, 8'h5A, 1'b0);
    repeat (5) step();
    do_req(1'b0, 3'd6, 8'hC3, 1'b0);
    repeat (5) step();

    do_req(1'b1, 3'd2, 8'hFF, 1'b0);
    repeat (6) step();

    for (int i = 0; i < 400; i++) begin
      if (!REQ_VALID) begin
        REQ_ADDR = AW'($urandom_range(0, 7));
        REQ_DATA = WIDTH'($urandom);
        REQ_SET  = ($urandom_range(0, 15) == 0);
        REQ_VALID = ($urandom_range(0, 1) == 1);
      end
      step();
      if (fired) REQ_VALID = 1'b0;
    end
    REQ_VALID = 1'b0;
    repeat (5) step();

    // asynchronous reset while the word-3 enable is open
    do_req(1'b0, 3'd3, 8'h3C, 1'b0);
    step();
    chk("open_e3", 64'(LAT_E), 64'(8));
    #1;
    do_reset();
    repeat (6) step();
    do_req(1'b0, 3'd4, 8'h96, 1'b0);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

endmodule
